// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter with sanitised preset load, cascade borrow and done pulse.
// Optional BCD_DOWN_AUTORELOAD_EN: wrap at zero reloads load_val instead of all 9s.
module bcd_down_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  borrow,
  output logic                  done
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'd9}};

  logic [W-1:0] load_clean;
  logic [W-1:0] count_dec;
  logic [W-1:0] count_next;
  logic         done_next;
  logic         chain;

  // Any preset digit A-F is clamped to 9 so count stays valid BCD.
  always_comb begin
    load_clean = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_clean[4*i +: 4] = 4'd9;
      end
    end
  end

  always_comb begin
    count_dec = count;
    chain     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (chain) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
        end
      end
      chain = chain & (count[4*i +: 4] == 4'd0);
    end
  end

  assign zero   = (count == '0);
  assign borrow = en & ~load & zero;

  // Priority load > en > hold; done only marks a 1 -> 0 decrement.
  always_comb begin
    count_next = count;
    done_next  = 1'b0;
    if (load) begin
      count_next = load_clean;
    end else if (en) begin
      if (zero) begin
`ifdef BCD_DOWN_AUTORELOAD_EN
        count_next = load_clean;
`else
        count_next = ALL_NINES;
`endif
      end else begin
        count_next = count_dec;
        done_next  = (count == ONE);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      count <= count_next;
      done  <= done_next;
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed, table-driven bench for bcd_down_counter (DIGITS=2), with hand sequences
// for wrap, periodic reload (BCD_DOWN_AUTORELOAD_EN) and asynchronous reset.
module tb_bcd_down_counter;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic [7:0] count;
  logic       zero;
  logic       borrow;
  logic       done;

  int total;
  int bad;

  typedef struct {
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic [7:0] exp_count;
    logic       exp_zero;
    logic       exp_borrow;
    logic       exp_done;
  } vec_t;

  vec_t vecs[19];
  logic [7:0] period_exp[8];

  bcd_down_counter #(.DIGITS(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .count    (count),
    .zero     (zero),
    .borrow   (borrow),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] c, input logic z,
                           input logic b, input logic d);
    check_output({tag, " count"}, count, c);
    check_output({tag, " zero"}, {7'd0, zero}, {7'd0, z});
    check_output({tag, " borrow"}, {7'd0, borrow}, {7'd0, b});
    check_output({tag, " done"}, {7'd0, done}, {7'd0, d});
  endtask

  // Drive inputs, then sample one time unit after the next rising edge.
  task automatic apply_stimulus(input logic l, input logic [7:0] lv, input logic e);
    load     = l;
    load_val = lv;
    en       = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{1'b1, 8'h25, 1'b0, 8'h25, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h25, 1'b1, 8'h24, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h25, 1'b1, 8'h23, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h25, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h10, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h10, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h02, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h02, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h02, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 8'hA3, 1'b0, 8'h93, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h47, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h47, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'hFC, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

`ifdef BCD_DOWN_AUTORELOAD_EN
    period_exp = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
`else
    period_exp = '{8'h02, 8'h01, 8'h00, 8'h99, 8'h98, 8'h97, 8'h96, 8'h95};
`endif

    reset    = 1'b1;
    load     = 1'b0;
    load_val = 8'h00;
    en       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 8'h00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i].load, vecs[i].load_val, vecs[i].en);
      check_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_zero,
                vecs[i].exp_borrow, vecs[i].exp_done);
    end

    // Wrap from zero: zero/borrow high before the edge.
    load     = 1'b0;
    load_val = 8'h03;
    en       = 1'b1;
    #1;
    check_output("prewrap borrow", {7'd0, borrow}, 8'h01);
    check_output("prewrap zero", {7'd0, zero}, 8'h01);
    @(posedge clk);
    #1;
`ifdef BCD_DOWN_AUTORELOAD_EN
    check_all("wrap", 8'h03, 1'b0, 1'b0, 1'b0);
`else
    check_all("wrap", 8'h99, 1'b0, 1'b0, 1'b0);
`endif

    apply_stimulus(1'b1, 8'h03, 1'b0);
    check_output("period load", count, 8'h03);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 8'h03, 1'b1);
      check_output($sformatf("period%0d count", i), count, period_exp[i]);
      check_output($sformatf("period%0d done", i), {7'd0, done},
                   {7'd0, (period_exp[i] == 8'h00)});
    end

    // Asynchronous reset while done is high.
    apply_stimulus(1'b1, 8'h01, 1'b0);
    apply_stimulus(1'b0, 8'h01, 1'b1);
    check_output("predone", {7'd0, done}, 8'h01);
    #1 reset = 1'b1;
    #1;
    check_output("async done", {7'd0, done}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset mid-count at 37.
    apply_stimulus(1'b1, 8'h38, 1'b0);
    apply_stimulus(1'b0, 8'h38, 1'b1);
    check_output("mid 37", count, 8'h37);
    en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_all("async mid", 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(1'b0, 8'h38, 1'b0);
    check_output("post reset hold", count, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
